// File: rtl/dtc_vote_pkg.sv
// Shared types and defaults for the decision-tree vote window.
// Optional early-close input enabled by DTC_VOTE_FLUSH_EN.
package dtc_vote_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int WIN_DEF    = 8;
  localparam int THRESH_DEF = 5;

  function automatic int cw_f(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/dtc_vote_counter.sv
// Per-window vote and sample counters with clear/increment enables.
// Clear wins over increment so the closing sample never leaks into the next window.
module dtc_vote_counter
  import dtc_vote_pkg::*;
#(
  parameter int WIN = WIN_DEF,
  parameter int CW  = cw_f(WIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          pred_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] idx_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clr_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(pred_i);
      idx_d = idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == CW'(WIN - 1));

endmodule

// File: rtl/dtc_vote_window.sv
// Majority/threshold vote over WIN classifier predictions, one result per window.
// Define DTC_VOTE_FLUSH_EN to add a flush input that closes a partial window early.
module dtc_vote_window
  import dtc_vote_pkg::*;
#(
  parameter  int WIN    = WIN_DEF,
  parameter  int THRESH = THRESH_DEF,
  localparam int CW     = cw_f(WIN)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef DTC_VOTE_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_pred,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_class,
  output logic [CW-1:0] out_count,
  output logic [CW-1:0] win_idx
);

  state_e        state_q, state_d;
  logic          cls_q, cls_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sum;
  logic          hs;
  logic          last;
  logic          close;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign hs        = in_valid & in_ready;
  assign sum       = cnt + CW'(hs & in_pred);

`ifdef DTC_VOTE_FLUSH_EN
  // A flush on an empty window only closes it if a sample lands now.
  assign close = (hs & last)
               | (flush & in_ready & (hs | (win_idx != '0)));
`else
  assign close = hs & last;
`endif

  dtc_vote_counter #(
    .WIN (WIN),
    .CW  (CW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (hs),
    .pred_i (in_pred),
    .clr_i  (close),
    .cnt_o  (cnt),
    .idx_o  (win_idx),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    ocnt_d  = ocnt_q;
    unique case (state_q)
      ACCUM: begin
        if (close) begin
          state_d = HOLD;
          ocnt_d  = sum;
          cls_d   = (int'(sum) >= THRESH);
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cls_q   <= 1'b0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign out_class = cls_q;
  assign out_count = ocnt_q;

endmodule

// File: tb/tb_dtc_vote_window.sv
// Bench for dtc_vote_window: vector table, corner sequences, random vs. model.
// Flush sequences are compiled in when DTC_VOTE_FLUSH_EN is defined.
module tb_dtc_vote_window;

  localparam int W0 = 8;
  localparam int T0 = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, p0, r0, rdy0, ov0, cls0;
  logic [3:0] cnt0, idx0;
  logic       v1, p1, r1, rdy1, ov1, cls1;
  logic [0:0] cnt1, idx1;
`ifdef DTC_VOTE_FLUSH_EN
  logic       fl0, fl1;
`endif

  always #5 clk = ~clk;

  dtc_vote_window #(.WIN(W0), .THRESH(T0)) u0 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DTC_VOTE_FLUSH_EN
    .flush     (fl0),
`endif
    .in_valid  (v0),
    .in_ready  (rdy0),
    .in_pred   (p0),
    .out_valid (ov0),
    .out_ready (r0),
    .out_class (cls0),
    .out_count (cnt0),
    .win_idx   (idx0)
  );

  dtc_vote_window #(.WIN(1), .THRESH(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DTC_VOTE_FLUSH_EN
    .flush     (fl1),
`endif
    .in_valid  (v1),
    .in_ready  (rdy1),
    .in_pred   (p1),
    .out_valid (ov1),
    .out_ready (r1),
    .out_class (cls1),
    .out_count (cnt1),
    .win_idx   (idx1)
  );

  typedef struct {
    bit v; bit p; bit r;
    bit rdy; bit ov; int cnt; bit cls; int idx;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Window model: samples seen, ones seen, and a pending result.
  int m_n, m_ones, m_cnt;
  bit m_hold, m_cls;

  task automatic chk(input string nm, input logic [31:0] act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_n = 0; m_ones = 0; m_hold = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic mcycle(input bit v, input bit p, input bit r,
                        input string nm);
    v0 = v; p0 = p; r0 = r;
    chk({nm, " in_ready"}, rdy0, int'(!m_hold));
    chk({nm, " out_valid"}, ov0, int'(m_hold));
    chk({nm, " win_idx"}, idx0, m_n);
    if (m_hold) begin
      chk({nm, " out_count"}, cnt0, m_cnt);
      chk({nm, " out_class"}, cls0, int'(m_cls));
    end
    if (!m_hold && v) begin
      m_n++;
      m_ones += p;
      if (m_n == W0) begin
        m_hold = 1; m_cnt = m_ones; m_cls = (m_ones >= T0);
        m_n = 0; m_ones = 0;
      end
    end else if (m_hold && r) begin
      m_hold = 0;
    end
    tick();
  endtask

  function automatic vec_t mk(bit v, bit p, bit r, bit rdy, bit ov,
                              int cnt, bit cls, int idx);
    vec_t x;
    x.v = v; x.p = p; x.r = r; x.rdy = rdy; x.ov = ov;
    x.cnt = cnt; x.cls = cls; x.idx = idx;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   pat1[8] = '{1, 1, 0, 1, 1, 0, 1, 0};
    int   pat5[3] = '{1, 0, 1};

    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, pat1[i][0], 1, 1, 0, 0, 0, i));
    tbl.push_back(mk(0, 0, 1, 0, 1, 5, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, (i % 2 == 0), 0, 1, 0, 0, 0, i));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 1, 0, 0, 1, 4, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 4, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));

    rst_n = 1'b0;
    v0 = 0; p0 = 0; r0 = 0;
    v1 = 0; p1 = 0; r1 = 0;
`ifdef DTC_VOTE_FLUSH_EN
    fl0 = 0; fl1 = 0;
`endif
    #3;
    chk("reset out_valid", ov0, 0);
    chk("reset win_idx", idx0, 0);
    chk("reset out_count", cnt0, 0);
    chk("reset out_class", cls0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset in_ready", rdy0, 1);

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      v0 = tbl[i].v; p0 = tbl[i].p; r0 = tbl[i].r;
      chk({nm, " in_ready"}, rdy0, int'(tbl[i].rdy));
      chk({nm, " out_valid"}, ov0, int'(tbl[i].ov));
      chk({nm, " win_idx"}, idx0, tbl[i].idx);
      if (tbl[i].ov) begin
        chk({nm, " out_count"}, cnt0, tbl[i].cnt);
        chk({nm, " out_class"}, cls0, int'(tbl[i].cls));
      end
      tick();
    end

    do_reset();
    for (int i = 0; i < 16; i++)
      mcycle((i % 2 == 0), 1, 1, "t3 toggle");
    chk("t3 count8", cnt0, 8);
    mcycle(0, 1, 1, "t3 result");

    for (int i = 0; i < 3; i++)
      mcycle(1, 1, 1, "t4 pre");
    rst_n = 1'b0;
    #1;
    chk("t4 async win_idx", idx0, 0);
    chk("t4 async out_valid", ov0, 0);
    chk("t4 async out_count", cnt0, 0);
    tick();
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++)
      mcycle(1, 0, 1, "t4 zeros");
    mcycle(0, 0, 1, "t4 result");
    mcycle(0, 0, 1, "t4 after");

    for (int i = 0; i < 3; i++) begin
      v1 = 1; p1 = pat5[i][0]; r1 = 1;
      chk($sformatf("t5 s%0d in_ready", i), rdy1, 1);
      tick();
      p1 = ~pat5[i][0];
      chk($sformatf("t5 s%0d out_valid", i), ov1, 1);
      chk($sformatf("t5 s%0d out_count", i), cnt1, pat5[i]);
      chk($sformatf("t5 s%0d out_class", i), cls1, pat5[i]);
      chk($sformatf("t5 s%0d hold ready", i), rdy1, 0);
      tick();
    end
    v1 = 0;

`ifdef DTC_VOTE_FLUSH_EN
    fl0 = 1;
    mcycle(0, 0, 1, "t6 idle flush");
    fl0 = 0;
    for (int i = 0; i < 3; i++)
      mcycle(1, 1, 1, "t6 ones");
    v0 = 1; p0 = 0; r0 = 0; fl0 = 1;
    chk("t6 flush idx", idx0, 3);
    tick();
    v0 = 0;
    chk("t6 out_valid", ov0, 1);
    chk("t6 out_count", cnt0, 3);
    chk("t6 out_class", cls0, 0);
    tick();
    chk("t6 hold flush valid", ov0, 1);
    chk("t6 hold flush count", cnt0, 3);
    fl0 = 0; r0 = 1;
    tick();
    chk("t6 next in_ready", rdy0, 1);
    chk("t6 next win_idx", idx0, 0);
    model_clear();
`endif

    for (int i = 0; i < 800; i++)
      mcycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
